pc_gen: RTL

- Next-generation program-counter unit for the single-cycle/five-stage RISC-V core.
- Generalises the combinational next-PC select into a registered PC generator with parametrised width and vectors.
- Adds stall hold, a pending-redirect buffer, a trap vector and target-misalignment detection.
- Feeds instruction fetch (pc_o) and receives redirect requests from execute.

---
 rtl/pc_gen.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/pc_gen.sv
// Registered program-counter generator: sequential step, branch/jalr/trap redirect,
// stall hold with a pending-redirect buffer. Optional macro PC_GEN_RVC_EN enables 16-bit stepping.
//
// state | meaning
// RUN   | PC advances or redirects each unstalled cycle
// HOLD  | stalled with a redirect waiting in the pending buffer
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic [1:0]      sel_i,
  input  logic [XLEN-1:0] br_target_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic            is_compressed_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_next_seq_o,
  output logic            redirect_o,
  output logic            pending_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] misalign_addr_o
);

  typedef enum logic {RUN, HOLD} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
  logic [XLEN-1:0] pend_raw_q, pend_raw_d;
  logic            pend_mis_q, pend_mis_d;
  logic            pend_trap_q, pend_trap_d;
  logic            redirect_q, redirect_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;

  logic            redir_req, is_trap, mis;
  logic [XLEN-1:0] raw_tgt, tgt, step;

`ifdef PC_GEN_RVC_EN
  logic unused_bits;
  assign unused_bits = alu_result_i[0];
  assign step = is_compressed_i ? XLEN'(2) : XLEN'(4);
`else
  logic [1:0] unused_bits;
  assign unused_bits = {is_compressed_i, alu_result_i[0]};
  assign step = XLEN'(4);
`endif

  // Undefined sel values fall to the default arm and decode as sequential.
  always_comb begin
    redir_req = 1'b0;
    raw_tgt   = TRAP_VECTOR;
    mis       = 1'b0;
    case (sel_i)
      2'd1: begin
        redir_req = 1'b1;
        raw_tgt   = br_target_i;
      end
      2'd2: begin
        redir_req = 1'b1;
        raw_tgt   = {alu_result_i[XLEN-1:1], 1'b0};
      end
      2'd3: redir_req = 1'b1;
      default: redir_req = 1'b0;
    endcase
    if (redir_req && sel_i != 2'd3) begin
`ifdef PC_GEN_RVC_EN
      mis = raw_tgt[0];
`else
      mis = raw_tgt[1];
`endif
    end
    is_trap = redir_req && (sel_i == 2'd3 || mis);
    tgt     = mis ? TRAP_VECTOR : raw_tgt;
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    pend_tgt_d      = pend_tgt_q;
    pend_raw_d      = pend_raw_q;
    pend_mis_d      = pend_mis_q;
    pend_trap_d     = pend_trap_q;
    redirect_d      = 1'b0;
    misalign_d      = 1'b0;
    misalign_addr_d = misalign_addr_q;
    case (state_q)
      RUN: begin
        if (!stall_i) begin
          if (redir_req) begin
            pc_d       = tgt;
            redirect_d = 1'b1;
            misalign_d = mis;
            if (mis) misalign_addr_d = raw_tgt;
          end else begin
            pc_d = pc_q + step;
          end
        end else if (redir_req) begin
          pend_tgt_d  = tgt;
          pend_raw_d  = raw_tgt;
          pend_mis_d  = mis;
          pend_trap_d = is_trap;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (!stall_i) begin
          // The buffered redirect is older than anything presented now, so it wins.
          pc_d        = pend_tgt_q;
          redirect_d  = 1'b1;
          misalign_d  = pend_mis_q;
          if (pend_mis_q) misalign_addr_d = pend_raw_q;
          pend_trap_d = 1'b0;
          pend_mis_d  = 1'b0;
          state_d     = RUN;
        end else if (redir_req && (sel_i == 2'd3 || !pend_trap_q)) begin
          pend_tgt_d  = tgt;
          pend_raw_d  = raw_tgt;
          pend_mis_d  = mis;
          pend_trap_d = is_trap;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= RUN;
      pc_q            <= RESET_VECTOR;
      pend_tgt_q      <= '0;
      pend_raw_q      <= '0;
      pend_mis_q      <= 1'b0;
      pend_trap_q     <= 1'b0;
      redirect_q      <= 1'b0;
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      pend_tgt_q      <= pend_tgt_d;
      pend_raw_q      <= pend_raw_d;
      pend_mis_q      <= pend_mis_d;
      pend_trap_q     <= pend_trap_d;
      redirect_q      <= redirect_d;
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  assign pc_o            = pc_q;
  assign pc_next_seq_o   = pc_q + step;
  assign redirect_o      = redirect_q;
  assign pending_o       = (state_q == HOLD);
  assign misalign_o      = misalign_q;
  assign misalign_addr_o = misalign_addr_q;

endmodule
